// File: rtl/ser_feed.sv
// ser_feed: parallel-to-serial feeder with a one-word holding register.
// A word loaded while the previous one is still shifting follows it with
// no idle bit. serOut/serValid drive a downstream serial consumer.
module ser_feed #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [N-1:0] parIn,
    output logic         ready,
    output logic         serOut,
    output logic         serValid,
    output logic         busy,
    output logic         done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  hold;
    logic          holdFull;
    logic [N-1:0]  sreg;
    logic [CW-1:0] cnt;
    logic          last_bit;
    logic          xfer;
    logic          accept;

    assign last_bit = (cnt == CW'(N - 1));

    // Load is accepted only into an empty holding register; no bypass into sreg.
    assign accept = ld && !holdFull;

    // Next-state decode and hold-to-sreg transfer decision.
    always_comb begin
        state_nxt = state;
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                if (holdFull) begin
                    xfer      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    if (holdFull) begin
                        xfer      = 1'b1;
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, holding register, shift register and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold     <= '0;
            holdFull <= 1'b0;
            sreg     <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                sreg     <= hold;
                cnt      <= '0;
                holdFull <= 1'b0;
            end else if (state == SHIFT) begin
                if (MSB_FIRST)
                    sreg <= {sreg[N-2:0], 1'b0};
                else
                    sreg <= {1'b0, sreg[N-1:1]};
                cnt <= cnt + CW'(1);
            end
            // accept needs holdFull=0 and xfer needs holdFull=1, so they never collide.
            if (accept) begin
                hold     <= parIn;
                holdFull <= 1'b1;
            end
        end
    end

    // Output decode purely from registered state.
    always_comb begin
        ready    = !holdFull;
        serValid = (state == SHIFT);
        serOut   = serValid && (MSB_FIRST ? sreg[N-1] : sreg[0]);
        done     = serValid && last_bit;
        busy     = (state == SHIFT) || holdFull;
    end

endmodule

// File: tb/tb_ser_feed.sv
// tb_ser_feed: self-checking bench for ser_feed (MSB-first and LSB-first
// instances sharing the same stimulus) with a word-level reference model.
module tb_ser_feed;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ld = 1'b0;
    logic [N-1:0] parIn = '0;
    logic         ready, serOut, serValid, busy, done;
    logic         ready_l, serOut_l, serValid_l, busy_l, done_l;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ser_feed #(.N(N), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .ld(ld), .parIn(parIn),
        .ready(ready), .serOut(serOut), .serValid(serValid),
        .busy(busy), .done(done)
    );

    ser_feed #(.N(N), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .ld(ld), .parIn(parIn),
        .ready(ready_l), .serOut(serOut_l), .serValid(serValid_l),
        .busy(busy_l), .done(done_l)
    );

    always #5 clk = ~clk;

    // Reference model: a held word plus a word in flight with bits remaining.
    logic         m_held;
    logic [N-1:0] m_hword;
    logic [N-1:0] m_word;
    int           m_rem;
    logic         e_vld, e_msb, e_lsb, e_done, e_busy, e_ready;

    always @(posedge clk) begin
        if (rst) begin
            m_held  <= 1'b0;
            m_hword <= '0;
            m_word  <= '0;
            m_rem   <= 0;
        end else begin
            if (m_held && m_rem <= 1) begin
                m_word <= m_hword;
                m_rem  <= N;
                m_held <= 1'b0;
            end else if (m_rem > 0) begin
                m_rem <= m_rem - 1;
            end
            if (ld && !m_held) begin
                m_held  <= 1'b1;
                m_hword <= parIn;
            end
        end
    end

    always_comb begin
        e_vld   = (m_rem > 0);
        e_msb   = 1'b0;
        e_lsb   = 1'b0;
        if (e_vld) begin
            e_msb = m_word[N - 1 - (N - m_rem)];
            e_lsb = m_word[N - m_rem];
        end
        e_done  = (m_rem == 1);
        e_ready = !m_held;
        e_busy  = e_vld || m_held;
    end

    // Bench-side sequence detector for pattern 1011 on valid bits.
    logic [2:0] det_hist;
    logic       det;
    assign det = serValid && ({det_hist, serOut} == 4'b1011);
    always @(posedge clk) begin
        if (rst) det_hist <= '0;
        else if (serValid) det_hist <= {det_hist[1:0], serOut};
    end

    logic q_msb[$];
    logic q_lsb[$];
    int   done_cnt, done_idx, first_vld, last_vld, det_cnt;

    task automatic clear_log();
        q_msb.delete();
        q_lsb.delete();
        done_cnt  = 0;
        done_idx  = -1;
        first_vld = -1;
        last_vld  = -1;
        det_cnt   = 0;
    endtask

    // Advance one clock and log the serial streams after the edge settles.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (serValid) begin
            q_msb.push_back(serOut);
            if (first_vld < 0) first_vld = cyc;
            last_vld = cyc;
        end
        if (serValid_l) q_lsb.push_back(serOut_l);
        if (done) begin
            done_cnt++;
            done_idx = q_msb.size();
        end
        if (det) det_cnt++;
    endtask

    task automatic load(input logic [N-1:0] w);
        ld = 1'b1;
        parIn = w;
        tick();
        ld = 1'b0;
        parIn = $urandom();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || busy_l) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (busy || busy_l) begin
            errors++;
            $display("FAIL %s timeout: busy=%0b still set after %0d cycles, want 0", name, busy, n);
        end
    endtask

    function automatic logic [31:0] packq(input logic q[$]);
        logic [31:0] v = '0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        ld = 1'b1;
        parIn = 8'hFF;
        tick();
        tick();
        ld = 1'b0;
        rst = 1'b0;
        checks++; if (ready !== 1'b1)    begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if (serValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", serValid); end
        checks++; if (serOut !== 1'b0)   begin errors++; $display("FAIL reset_serout: got %b want 0", serOut); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        clear_log();
        repeat (4) tick();
        checks++;
        if (q_msb.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop_load: got %0d bits busy=%b want 0 bits busy=0", q_msb.size(), busy);
        end
    endtask

    task automatic test_single();
        clear_log();
        load(8'hB4);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL single_held_ready: got %b want 0", ready); end
        checks++; if (serValid !== 1'b0) begin errors++; $display("FAIL single_latency_early: got %b want 0", serValid); end
        tick();
        checks++;
        if (serValid !== 1'b1 || serOut !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: got valid=%b out=%b want valid=1 out=1", serValid, serOut);
        end
        wait_idle("single");
        checks++;
        if (q_msb.size() != N || packq(q_msb) !== 32'hB4) begin
            errors++;
            $display("FAIL single_stream: got %0d bits %h want 8 bits b4", q_msb.size(), packq(q_msb));
        end
        checks++;
        if (done_cnt != 1 || done_idx != N) begin
            errors++;
            $display("FAIL single_done: got %0d pulses at bit %0d want 1 pulse at bit 8", done_cnt, done_idx);
        end
        checks++; if (busy !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL single_idle: got busy=%b ready=%b want 0 1", busy, ready); end
    endtask

    task automatic test_back_to_back();
        clear_log();
        load(8'hF0);
        tick();
        load(8'h0F);
        wait_idle("b2b");
        checks++;
        if (q_msb.size() != 2*N || packq(q_msb) !== 32'hF00F) begin
            errors++;
            $display("FAIL b2b_stream: got %0d bits %h want 16 bits f00f", q_msb.size(), packq(q_msb));
        end
        checks++; if (done_cnt != 2) begin errors++; $display("FAIL b2b_done: got %0d pulses want 2", done_cnt); end
        checks++;
        if (last_vld - first_vld != 2*N - 1) begin
            errors++;
            $display("FAIL b2b_gap: got span %0d cycles want %0d", last_vld - first_vld + 1, 2*N);
        end
    endtask

    task automatic test_ignored_load();
        clear_log();
        load(8'h55);
        tick();
        load(8'h33);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ignore_ready: got %b want 0", ready); end
        load(8'hFF);
        checks++; if (ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ignore_state: got ready=%b busy=%b want 0 1", ready, busy); end
        wait_idle("ignore");
        checks++;
        if (q_msb.size() != 2*N || packq(q_msb) !== 32'h5533) begin
            errors++;
            $display("FAIL ignore_stream: got %0d bits %h want 16 bits 5533", q_msb.size(), packq(q_msb));
        end
    endtask

    task automatic test_reset_midword();
        clear_log();
        load(8'hAA);
        tick();
        ld = 1'b1;
        parIn = 8'h77;
        tick();
        ld = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (serValid !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: got valid=%b ready=%b busy=%b want 0 1 0", serValid, ready, busy);
        end
        repeat (12) tick();
        checks++; if (q_msb.size() != 3) begin errors++; $display("FAIL rstmid_flush: got %0d bits want 3", q_msb.size()); end
        load(8'h81);
        wait_idle("rstmid");
        checks++;
        if (q_msb.size() != 11 || packq(q_msb) !== {21'd0, 3'b101, 8'h81}) begin
            errors++;
            $display("FAIL rstmid_stream: got %0d bits %h want 11 bits %h", q_msb.size(), packq(q_msb), {21'd0, 3'b101, 8'h81});
        end
    endtask

    task automatic test_lsb_first();
        clear_log();
        load(8'h01);
        wait_idle("lsb");
        checks++;
        if (q_lsb.size() != N || packq(q_lsb) !== 32'h80) begin
            errors++;
            $display("FAIL lsb_stream: got %0d bits %h want 8 bits 80 (1 then seven 0)", q_lsb.size(), packq(q_lsb));
        end
    endtask

    task automatic test_detector();
        logic [15:0] bits;
        int exp_det;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_log();
        load(8'hB4);
        tick();
        load(8'hBB);
        wait_idle("detector");
        bits = 16'hB4BB;
        exp_det = 0;
        for (int i = 15; i >= 3; i--)
            if (bits[i -: 4] == 4'b1011) exp_det++;
        checks++;
        if (det_cnt != exp_det) begin
            errors++;
            $display("FAIL detector_hits: got %0d want %0d", det_cnt, exp_det);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            ld    = ($urandom_range(0, 2) == 0);
            parIn = $urandom();
            tick();
            checks++; if (ready !== e_ready)      begin errors++; $display("FAIL rand_ready @%0d: got %b want %b", cyc, ready, e_ready); end
            checks++; if (serValid !== e_vld)     begin errors++; $display("FAIL rand_valid @%0d: got %b want %b", cyc, serValid, e_vld); end
            checks++; if (serOut !== e_msb)       begin errors++; $display("FAIL rand_msb @%0d: got %b want %b", cyc, serOut, e_msb); end
            checks++; if (serOut_l !== e_lsb)     begin errors++; $display("FAIL rand_lsb @%0d: got %b want %b", cyc, serOut_l, e_lsb); end
            checks++; if (done !== e_done)        begin errors++; $display("FAIL rand_done @%0d: got %b want %b", cyc, done, e_done); end
            checks++; if (busy !== e_busy)        begin errors++; $display("FAIL rand_busy @%0d: got %b want %b", cyc, busy, e_busy); end
            checks++; if (done_l !== e_done || serValid_l !== e_vld) begin
                errors++; $display("FAIL rand_lsb_ctl @%0d: got done=%b valid=%b want %b %b", cyc, done_l, serValid_l, e_done, e_vld);
            end
        end
        rst = 1'b0;
        ld = 1'b0;
        wait_idle("random");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignored_load();
        test_reset_midword();
        test_lsb_first();
        test_detector();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
